// File: rtl/workshop_button_conditioner_pkg.sv
// Shared types and sizing helpers for the workshop button conditioner.
package workshop_button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  // Bits needed to hold values 0..max_count inclusive.
  function automatic int unsigned count_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/workshop_button_conditioner_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and a single-cycle pulse registered on each accepted 0->1 change.
module workshop_debounce
  import workshop_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = count_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter value seen at the DEBOUNCE_CYCLES-th mismatch is LAST, so the
  // flip happens on that edge rather than one cycle later.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/workshop_button_conditioner.sv
// Button/switch front end: debounced step (with auto-repeat) and load pulses
// plus synchronised switch data for the downstream workshop counter.
module workshop_button_conditioner
  import workshop_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       btn_load,
  input  logic [3:0] sw_in,
  output logic       en_out,
  output logic       load_out,
  output logic [3:0] data_out
);

  localparam int unsigned TW = count_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TW-1:0] DELAY_LD  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] PERIOD_LD = TW'(REPEAT_PERIOD);

  logic          step_level, step_rise;
  logic          load_level, load_rise;
  logic [3:0]    sw_s1_q, sw_s2_q;
  step_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          step_pulse;

  workshop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_step),
    .level_o (step_level),
    .rise_o  (step_rise)
  );

  workshop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_load),
    .level_o (load_level),
    .rise_o  (load_rise)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    step_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (step_rise) begin
          step_pulse = 1'b1;
          if (REPEAT_EN != 0) begin
            state_d = ST_FIRST;
            timer_d = DELAY_LD;
          end
        end
      end
      ST_FIRST, ST_REPEAT: begin
        if (!step_level) begin
          state_d = ST_IDLE;
        end else if (timer_q <= TW'(1)) begin
          step_pulse = 1'b1;
          timer_d    = PERIOD_LD;
          state_d    = ST_REPEAT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Load wins a collision simply because both pulses share en_out; the step
  // pulse is never queued. Outputs are masked while rst is high.
  assign en_out   = !rst && (step_pulse || load_rise);
  assign load_out = !rst && load_rise;
  assign data_out = sw_s2_q;

  logic unused_load_level;
  assign unused_load_level = load_level;

endmodule

// File: tb/tb_workshop_button_conditioner.sv
// Directed table-driven bench for workshop_button_conditioner (D=4, delay 8, period 4).
module tb_workshop_button_conditioner;

  logic       clk = 1'b0;
  logic       rst, btn_step, btn_load;
  logic [3:0] sw_in;
  logic       en_out, load_out, en_nr, load_nr;
  logic [3:0] data_out, data_nr;

  always #5 clk = ~clk;

  workshop_button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .btn_load(btn_load), .sw_in(sw_in),
    .en_out(en_out), .load_out(load_out), .data_out(data_out)
  );

  workshop_button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) u_norep (
    .clk(clk), .rst(rst), .btn_step(btn_step), .btn_load(btn_load), .sw_in(sw_in),
    .en_out(en_nr), .load_out(load_nr), .data_out(data_nr)
  );

  typedef struct {
    logic       step;
    logic       load;
    logic [3:0] sw;
    logic       en;
    logic       ld;
    logic       en_nr;
  } vec_t;

  vec_t        tbl[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [3:0]  prev_sw;

  task automatic chk(input string name, input int unsigned idx,
                     input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic l, input logic [3:0] sw,
                     input logic en, input logic ld, input logic en0);
    vec_t v;
    v.step = s; v.load = l; v.sw = sw; v.en = en; v.ld = ld; v.en_nr = en0;
    tbl.push_back(v);
  endtask

  task automatic idle(input int unsigned n, input logic [3:0] sw);
    for (int unsigned i = 0; i < n; i++) add(1'b0, 1'b0, sw, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Row i: inputs sampled at edge i, outputs checked in the cycle after edge i.
    idle(4, 4'h0);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 4'h0, i == 5, 1'b0, i == 5);
    idle(10, 4'h0);
    for (int i = 0; i < 40; i++)
      add(i < 30, 1'b0, 4'h0, (i == 5) || (i >= 13 && i <= 33 && (i - 13) % 4 == 0),
          1'b0, i == 5);
    idle(6, 4'h0);
    for (int i = 0; i < 20; i++)
      add((i >= 12) || ((i / 2) % 2 == 0), 1'b0, 4'h0, i == 17, 1'b0, i == 17);
    idle(10, 4'h0);
    idle(3, 4'hA);
    for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 4'hA, i == 5, i == 5, i == 5);
    idle(8, 4'hA);
    for (int i = 0; i < 14; i++) add(i < 4, i < 4, 4'h5, i == 5, i == 5, i == 5);
    idle(4, 4'h5);

    rst = 1'b1; btn_step = 1'b0; btn_load = 1'b0; sw_in = 4'h0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i == 3) rst = 1'b0;
      cyc();
      chk("rst_en", i, 4'(en_out), 4'h0);
      chk("rst_load", i, 4'(load_out), 4'h0);
      chk("rst_data", i, data_out, 4'h0);
    end

    prev_sw = 4'h0;
    foreach (tbl[i]) begin
      btn_step = tbl[i].step;
      btn_load = tbl[i].load;
      sw_in    = tbl[i].sw;
      cyc();
      chk("en", i, 4'(en_out), 4'(tbl[i].en));
      chk("load", i, 4'(load_out), 4'(tbl[i].ld));
      chk("data", i, data_out, prev_sw);
      chk("en_norep", i, 4'(en_nr), 4'(tbl[i].en_nr));
      chk("load_norep", i, 4'(load_nr), 4'(tbl[i].ld));
      chk("data_norep", i, data_nr, prev_sw);
      prev_sw = tbl[i].sw;
    end

    sw_in = 4'h0;
    for (int unsigned i = 0; i < 3; i++) cyc();

    // Reset in the middle of an auto-repeat hold, button kept pressed throughout.
    btn_step = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      cyc();
      chk("pre_rst_en", i, 4'(en_out), 4'(i == 5));
    end
    rst = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      cyc();
      chk("mid_rst_en", i, 4'(en_out), 4'h0);
      chk("mid_rst_en_norep", i, 4'(en_nr), 4'h0);
      chk("mid_rst_data", i, data_out, 4'h0);
    end
    rst = 1'b0;
    for (int unsigned i = 0; i < 18; i++) begin
      if (i == 8) btn_step = 1'b0;
      cyc();
      chk("held_rst_en", i, 4'(en_out), 4'(i == 5));
      chk("held_rst_en_norep", i, 4'(en_nr), 4'(i == 5));
      chk("held_rst_load", i, 4'(load_out), 4'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
